wcc_phase_ctrl: RTL and testbench

- Per-PE sequencer for the WCC processing pipe.
- Walks every partition through scatter (control=1), then every partition through gather (control=2), once per iteration.
- Handshakes partition buffer load/store and stream-length fetch with the memory/DMA side.
- Tracks which partitions changed labels, skips inactive partitions in scatter, and stops on convergence or an iteration cap.

---
 rtl/wcc_ctrl_pkg.sv | 24 ++
 rtl/wcc_phase_ctrl_if.sv | 24 ++
 rtl/wcc_active_tracker.sv | 51 +++++
 rtl/wcc_phase_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_wcc_phase_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/wcc_ctrl_pkg.sv
// Shared types and encodings for the WCC per-PE phase sequencer.
package wcc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_STREAM,
        S_DRAIN,
        S_STORE,
        S_NEXT,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_SCATTER = 1'b0,
        PH_GATHER  = 1'b1
    } phase_t;

    localparam logic [1:0] CTRL_IDLE    = 2'd0;
    localparam logic [1:0] CTRL_SCATTER = 2'd1;
    localparam logic [1:0] CTRL_GATHER  = 2'd2;

endpackage

// File: rtl/wcc_phase_ctrl_if.sv
// Memory/DMA-side handshake bundle of the phase sequencer.
interface wcc_phase_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_req;
    logic             load_done;
    logic             cnt_req;
    logic             cnt_ack;
    logic [CNT_W-1:0] cnt_len;
    logic             stream_valid;
    logic             store_req;
    logic             store_done;
    logic             par_active;

    modport master (
        output load_req, cnt_req, store_req,
        input  load_done, cnt_ack, cnt_len, stream_valid, store_done, par_active
    );

    modport slave (
        input  load_req, cnt_req, store_req,
        output load_done, cnt_ack, cnt_len, stream_valid, store_done, par_active
    );
endinterface

// File: rtl/wcc_active_tracker.sv
// Active/next partition bitmaps. next collects changes seen during gather;
// commit promotes it to active for the following iteration's scatter.
module wcc_active_tracker #(
    parameter int NUM_PAR  = 16,
    parameter int PAR_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic                set,
    input  logic [PAR_ID_W-1:0] set_idx,
    input  logic                commit,
    input  logic [PAR_ID_W-1:0] qry_idx,
    output logic                act,
    output logic                any_next
);
    logic [NUM_PAR-1:0] active_q, active_d;
    logic [NUM_PAR-1:0] next_q, next_d;

    // Bitmap update: init wins, otherwise set and commit never coincide.
    always_comb begin
        active_d = active_q;
        next_d   = next_q;
        if (init) begin
            active_d = '1;
            next_d   = '0;
        end else begin
            if (set) next_d[set_idx] = 1'b1;
            if (commit) begin
                active_d = next_q;
                next_d   = '0;
            end
        end
    end

    // Bitmap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '1;
            next_q   <= '0;
        end else begin
            active_q <= active_d;
            next_q   <= next_d;
        end
    end

    // During commit the lookup bypasses to the bitmap about to become active.
    assign act      = commit ? next_q[qry_idx] : active_q[qry_idx];
    assign any_next = |next_q;

endmodule

// File: rtl/wcc_phase_ctrl.sv
// Per-PE scatter/gather sequencer: walks partitions through load, length
// fetch, stream, drain and (gather) store, iterating until no partition
// changes or the iteration cap is reached.
module wcc_phase_ctrl
    import wcc_ctrl_pkg::*;
#(
    parameter int NUM_PAR   = 16,
    parameter int PAR_ID_W  = 4,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4,
    parameter int ITER_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ITER_W-1:0]   max_iter,
    wcc_phase_ctrl_if.master    mem,
    output logic [1:0]          control,
    output logic [PAR_ID_W-1:0] cur_par,
    output logic [ITER_W-1:0]   iter,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic                proto_err
);
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [PAR_ID_W-1:0] par_q, par_d;
    logic [ITER_W-1:0]   iter_q, iter_d, max_q, max_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, len_q, len_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic                done_q, done_d, conv_q, conv_d, perr_q, perr_d;
    logic                busy_q, busy_d;
    logic                load_req_q, load_req_d, cnt_req_q, cnt_req_d;
    logic                store_req_q, store_req_d;
    logic [1:0]          control_q, control_d;

    logic                trk_init, trk_set, trk_commit, trk_act, trk_any;
    logic [PAR_ID_W-1:0] trk_idx, nxt_par;
    logic [ITER_W-1:0]   iter_inc;
    logic                last_par;

    assign nxt_par  = par_q + PAR_ID_W'(1);
    assign last_par = (par_q == PAR_ID_W'(NUM_PAR - 1));
    assign iter_inc = iter_q + ITER_W'(1);
    // Partition the NEXT state would move to; 0 when wrapping phase/iteration.
    assign trk_idx  = last_par ? '0 : nxt_par;

    wcc_active_tracker #(
        .NUM_PAR  (NUM_PAR),
        .PAR_ID_W (PAR_ID_W)
    ) u_trk (
        .clk      (clk),
        .rst      (rst),
        .init     (trk_init),
        .set      (trk_set),
        .set_idx  (par_q),
        .commit   (trk_commit),
        .qry_idx  (trk_idx),
        .act      (trk_act),
        .any_next (trk_any)
    );

    // Next-state and datapath; request/control outputs are derived from the
    // next state so they are registered and rise on state entry.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        par_d      = par_q;
        iter_d     = iter_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        drain_d    = drain_q;
        done_d     = done_q;
        conv_d     = conv_q;
        perr_d     = perr_q | (mem.stream_valid && state_q != S_STREAM);
        trk_init   = 1'b0;
        trk_commit = 1'b0;
        trk_set    = mem.par_active && phase_q == PH_GATHER &&
                     (state_q == S_STREAM || state_q == S_DRAIN);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    phase_d  = PH_SCATTER;
                    par_d    = '0;
                    iter_d   = '0;
                    max_d    = max_iter;
                    perr_d   = 1'b0;
                    done_d   = 1'b0;
                    conv_d   = 1'b0;
                    trk_init = 1'b1;
                end
            end
            S_LOAD: if (mem.load_done) state_d = S_FETCH;
            S_FETCH: begin
                if (mem.cnt_ack) begin
                    len_d   = mem.cnt_len;
                    cnt_d   = '0;
                    state_d = (mem.cnt_len == '0) ? S_NEXT : S_STREAM;
                end
            end
            S_STREAM: begin
                if (mem.stream_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DRN_W'(1);
                if (drain_q == DRN_W'(DRAIN_CYC - 1))
                    state_d = (phase_q == PH_GATHER) ? S_STORE : S_NEXT;
            end
            S_STORE: if (mem.store_done) state_d = S_NEXT;
            S_NEXT: begin
                if (!last_par) begin
                    par_d   = nxt_par;
                    // Inactive scatter partitions are passed over one per cycle.
                    state_d = (phase_q == PH_SCATTER && !trk_act) ? S_NEXT : S_LOAD;
                end else if (phase_q == PH_SCATTER) begin
                    phase_d = PH_GATHER;
                    par_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    iter_d     = iter_inc;
                    trk_commit = 1'b1;
                    if (!trk_any) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        conv_d  = 1'b1;
                    end else if (max_q != '0 && iter_inc == max_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        conv_d  = 1'b0;
                    end else begin
                        phase_d = PH_SCATTER;
                        par_d   = '0;
                        state_d = trk_act ? S_LOAD : S_NEXT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        load_req_d  = (state_d == S_LOAD);
        cnt_req_d   = (state_d == S_FETCH);
        store_req_d = (state_d == S_STORE);
        busy_d      = !(state_d == S_IDLE || state_d == S_DONE);
        control_d   = CTRL_IDLE;
        if (state_d == S_STREAM || state_d == S_DRAIN)
            control_d = (phase_d == PH_GATHER) ? CTRL_GATHER : CTRL_SCATTER;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_SCATTER;
            par_q       <= '0;
            iter_q      <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            drain_q     <= '0;
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            perr_q      <= 1'b0;
            busy_q      <= 1'b0;
            load_req_q  <= 1'b0;
            cnt_req_q   <= 1'b0;
            store_req_q <= 1'b0;
            control_q   <= CTRL_IDLE;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            par_q       <= par_d;
            iter_q      <= iter_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            conv_q      <= conv_d;
            perr_q      <= perr_d;
            busy_q      <= busy_d;
            load_req_q  <= load_req_d;
            cnt_req_q   <= cnt_req_d;
            store_req_q <= store_req_d;
            control_q   <= control_d;
        end
    end

    assign mem.load_req  = load_req_q;
    assign mem.cnt_req   = cnt_req_q;
    assign mem.store_req = store_req_q;
    assign control       = control_q;
    assign cur_par       = par_q;
    assign iter          = iter_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign converged     = conv_q;
    assign proto_err     = perr_q;

endmodule

// File: tb/tb_wcc_phase_ctrl.sv
// Directed bench for wcc_phase_ctrl with a two-partition configuration and a
// behavioural memory/DMA responder with configurable ack latency.
module tb_wcc_phase_ctrl;
    localparam int NUM_PAR  = 2;
    localparam int PAR_ID_W = 1;
    localparam int CNT_W    = 32;
    localparam int ITER_W   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ITER_W-1:0]   max_iter;
    logic [1:0]          control;
    logic [PAR_ID_W-1:0] cur_par;
    logic [ITER_W-1:0]   iter;
    logic                busy, done, converged, proto_err;

    wcc_phase_ctrl_if #(.CNT_W(CNT_W)) bif ();

    wcc_phase_ctrl #(
        .NUM_PAR   (NUM_PAR),
        .PAR_ID_W  (PAR_ID_W),
        .CNT_W     (CNT_W),
        .DRAIN_CYC (4),
        .ITER_W    (ITER_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_iter  (max_iter),
        .mem       (bif.master),
        .control   (control),
        .cur_par   (cur_par),
        .iter      (iter),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // responder configuration
    int lat, len_def, zidx, pa_mode;
    logic sv_force;
    int ld_w, cn_w, st_w, words_left, fetch_idx;
    // observation
    int n_load, n_store, n_c1, n_c2, acc_words;
    logic ld_p, st_p;
    logic [7:0] par_log;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // memory/DMA side: acks after lat cycles, streams cnt_len words
    always @(negedge clk) begin
        if (rst) begin
            bif.load_done = 0; bif.cnt_ack = 0; bif.store_done = 0;
            bif.stream_valid = 0; bif.par_active = 0; bif.cnt_len = '0;
            ld_w = 0; cn_w = 0; st_w = 0; words_left = 0; fetch_idx = 0;
        end else begin
            if (bif.load_done) bif.load_done = 0;
            else if (bif.load_req) begin
                if (ld_w >= lat) begin bif.load_done = 1; ld_w = 0; end else ld_w++;
            end else ld_w = 0;
            if (bif.cnt_ack) bif.cnt_ack = 0;
            else if (bif.cnt_req) begin
                if (cn_w >= lat) begin
                    bif.cnt_ack = 1;
                    bif.cnt_len = (fetch_idx == zidx) ? 0 : len_def;
                    words_left = int'(bif.cnt_len);
                    fetch_idx++;
                    cn_w = 0;
                end else cn_w++;
            end else cn_w = 0;
            if (bif.store_done) bif.store_done = 0;
            else if (bif.store_req) begin
                if (st_w >= lat) begin bif.store_done = 1; st_w = 0; end else st_w++;
            end else st_w = 0;
            if (sv_force) bif.stream_valid = 1;
            else if (control != 2'd0 && words_left > 0) begin
                bif.stream_valid = 1; words_left--;
            end else bif.stream_valid = 0;
            bif.par_active = (control == 2'd2) &&
                             (pa_mode == 2 || (pa_mode == 1 && cur_par == 1'b1 && iter == 0));
        end
    end

    // event monitor: request rises, partition order, control-cycle counts
    always @(negedge clk) begin
        if (bif.load_req && !ld_p) begin n_load++; par_log = {par_log[6:0], cur_par}; end
        if (bif.store_req && !st_p) n_store++;
        ld_p = bif.load_req;
        st_p = bif.store_req;
        if (control == 2'd1) n_c1++;
        if (control == 2'd2) n_c2++;
    end

    // accepted stream words
    always @(posedge clk) if (bif.stream_valid && control != 2'd0) acc_words++;

    task automatic clear_obs();
        n_load = 0; n_store = 0; n_c1 = 0; n_c2 = 0; acc_words = 0; par_log = '0;
    endtask

    task automatic launch(input int lat_i, input int len_i, input int zidx_i,
                          input int pam, input int mx);
        lat = lat_i; len_def = len_i; zidx = zidx_i; pa_mode = pam;
        fetch_idx = 0;
        clear_obs();
        start = 1; max_iter = ITER_W'(mx);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("perr_after_start", proto_err, 0);
        chk("done_after_start", done, 0);
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 4000) begin @(negedge clk); c++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 0; start = 0; max_iter = '0; sv_force = 0;
        lat = 0; len_def = 3; zidx = -1; pa_mode = 0;
        ld_p = 0; st_p = 0; clear_obs();
        bif.load_done = 0; bif.cnt_ack = 0; bif.store_done = 0;
        bif.stream_valid = 0; bif.par_active = 0; bif.cnt_len = '0;
        #1 rst = 1;
        #2;
        chk("rst_control", control, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter, 0);
        chk("rst_reqs", {bif.load_req, bif.cnt_req, bif.store_req}, 0);
        chk("rst_perr", proto_err, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // 1: no activity -> one scatter + one gather pass, converged
        launch(0, 3, -1, 0, 0);
        wait_done("t1");
        chk("t1_iter", iter, 1);
        chk("t1_conv", converged, 1);
        chk("t1_stores", n_store, 2);
        chk("t1_loads", n_load, 4);
        chk("t1_scat_cyc", n_c1, 14);
        chk("t1_gath_cyc", n_c2, 14);
        chk("t1_order", par_log, 8'b0000_0101);

        // 2: activity only in gather of partition 1, iteration 0 -> skip p0
        launch(0, 3, -1, 1, 0);
        wait_done("t2");
        chk("t2_iter", iter, 2);
        chk("t2_conv", converged, 1);
        chk("t2_loads", n_load, 7);
        chk("t2_order", par_log, 8'b0010_1101);
        chk("t2_scat_cyc", n_c1, 21);
        chk("t2_gath_cyc", n_c2, 28);
        chk("t2_stores", n_store, 4);

        // 3: always active, cap of 3 iterations
        launch(0, 3, -1, 2, 3);
        wait_done("t3");
        chk("t3_iter", iter, 3);
        chk("t3_conv", converged, 0);
        chk("t3_loads", n_load, 12);
        chk("t3_stores", n_store, 6);

        // 4: zero-length gather of partition 0 (fetch #2)
        launch(0, 3, 2, 0, 0);
        wait_done("t4");
        chk("t4_iter", iter, 1);
        chk("t4_conv", converged, 1);
        chk("t4_stores", n_store, 1);
        chk("t4_gath_cyc", n_c2, 7);
        chk("t4_scat_cyc", n_c1, 14);
        chk("t4_loads", n_load, 4);

        // 5: acks delayed 10 cycles -> same sequence as case 1
        launch(10, 3, -1, 0, 0);
        wait_done("t5");
        chk("t5_iter", iter, 1);
        chk("t5_conv", converged, 1);
        chk("t5_stores", n_store, 2);
        chk("t5_loads", n_load, 4);
        chk("t5_order", par_log, 8'b0000_0101);
        chk("t5_gath_cyc", n_c2, 14);

        // 6: reset after 2 of 5 words, then protocol error, then replay
        launch(0, 5, -1, 0, 0);
        begin
            int c;
            c = 0;
            while (acc_words < 2 && c < 200) begin @(posedge clk); #2; c++; end
            chk("t6_reach_word2", acc_words, 2);
        end
        chk("t6_streaming", control, 1);
        rst = 1;
        #1;
        chk("t6_rst_control", control, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_par", cur_par, 0);
        chk("t6_rst_reqs", {bif.load_req, bif.cnt_req, bif.store_req}, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #2 sv_force = 1;
        @(posedge clk); #2 sv_force = 0;
        chk("t6_perr_set", proto_err, 1);
        @(negedge clk);
        launch(0, 3, -1, 0, 0);
        wait_done("t6");
        chk("t6_iter", iter, 1);
        chk("t6_conv", converged, 1);
        chk("t6_order", par_log, 8'b0000_0101);
        chk("t6_perr_end", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
